// File: rtl/regsel_burst.sv
// Registered active-low one-hot OE/load strobe decoder for the register bus.
// Define REGSEL_BURST_EN to add the multi-register burst sequencer.
module regsel_burst #(
    parameter int REG_COUNT = 8,
    parameter int SEL_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 oe,
    input  logic                 load,
    input  logic [1:0]           oeSourceSel,
    input  logic                 loadSourceSel,
    input  logic [SEL_WIDTH-1:0] useqRegSelOE,
    input  logic [SEL_WIDTH-1:0] useqRegSelLoad,
    input  logic [SEL_WIDTH-1:0] op0,
    input  logic [SEL_WIDTH-1:0] op1,
    input  logic [SEL_WIDTH-1:0] op2,
    input  logic                 burstStart,
    input  logic [SEL_WIDTH:0]   burstCount,
    output logic                 burstBusy,
    output logic                 burstDone,
    output logic [REG_COUNT-1:0] regNotOEs,
    output logic [REG_COUNT-1:0] regNotLoads
);
    logic [SEL_WIDTH-1:0] oe_idx;
    logic [SEL_WIDTH-1:0] load_idx;
    logic [REG_COUNT-1:0] oe_n_reg, oe_n_next;
    logic [REG_COUNT-1:0] ld_n_reg, ld_n_next;

    // Indices with no matching register decode to all ones.
    function automatic logic [REG_COUNT-1:0] strobe_n(input logic en, input logic [SEL_WIDTH-1:0] idx);
        logic [REG_COUNT-1:0] v;
        v = '1;
        for (int k = 0; k < REG_COUNT; k++) begin
            if (en && idx == SEL_WIDTH'(k)) v[k] = 1'b0;
        end
        return v;
    endfunction

    always_comb begin
        case (oeSourceSel)
            2'd0:    oe_idx = useqRegSelOE;
            2'd1:    oe_idx = op0;
            2'd2:    oe_idx = op1;
            default: oe_idx = op2;
        endcase
        load_idx = loadSourceSel ? op0 : useqRegSelLoad;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            oe_n_reg <= '1;
            ld_n_reg <= '1;
        end else begin
            oe_n_reg <= oe_n_next;
            ld_n_reg <= ld_n_next;
        end
    end

    assign regNotOEs   = oe_n_reg;
    assign regNotLoads = ld_n_reg;

`ifdef REGSEL_BURST_EN
    localparam logic [SEL_WIDTH:0]   CNT_MAX  = (SEL_WIDTH+1)'(REG_COUNT);
    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(REG_COUNT - 1);
    localparam logic [SEL_WIDTH-1:0] RC_LOW   = SEL_WIDTH'(REG_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_reg, state_next;
    logic [SEL_WIDTH-1:0] src_reg, src_next;
    logic [SEL_WIDTH-1:0] dst_reg, dst_next;
    logic [SEL_WIDTH:0]   remain_reg, remain_next;
    logic                 m_oe_reg, m_oe_next;
    logic                 m_ld_reg, m_ld_next;
    logic [SEL_WIDTH:0]   cnt_clamped;
    logic [SEL_WIDTH-1:0] src_start, dst_start;

    // Out-of-range start indices fold back into range so the walk is modulo REG_COUNT.
    function automatic logic [SEL_WIDTH-1:0] wrap_idx(input logic [SEL_WIDTH-1:0] idx);
        return ({1'b0, idx} >= CNT_MAX) ? idx - RC_LOW : idx;
    endfunction

    function automatic logic [SEL_WIDTH-1:0] next_idx(input logic [SEL_WIDTH-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        cnt_clamped = (burstCount > CNT_MAX) ? CNT_MAX : burstCount;
        src_start   = wrap_idx(oe_idx);
        dst_start   = wrap_idx(load_idx);
        state_next  = state_reg;
        src_next    = src_reg;
        dst_next    = dst_reg;
        remain_next = remain_reg;
        m_oe_next   = m_oe_reg;
        m_ld_next   = m_ld_reg;
        oe_n_next   = '1;
        ld_n_next   = '1;
        case (state_reg)
            RUN: begin
                if (remain_reg == '0) begin
                    state_next = DONE;
                end else begin
                    oe_n_next   = strobe_n(m_oe_reg, src_reg);
                    ld_n_next   = strobe_n(m_ld_reg, dst_reg);
                    src_next    = next_idx(src_reg);
                    dst_next    = next_idx(dst_reg);
                    remain_next = remain_reg - 1'b1;
                end
            end
            default: begin
                // DONE is followed by an ordinary IDLE edge.
                if (burstStart) begin
                    m_oe_next = oe;
                    m_ld_next = load;
                    if (cnt_clamped == '0) begin
                        state_next  = DONE;
                        remain_next = '0;
                    end else begin
                        state_next  = RUN;
                        oe_n_next   = strobe_n(oe, src_start);
                        ld_n_next   = strobe_n(load, dst_start);
                        src_next    = next_idx(src_start);
                        dst_next    = next_idx(dst_start);
                        remain_next = cnt_clamped - 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                    oe_n_next  = strobe_n(oe, oe_idx);
                    ld_n_next  = strobe_n(load, load_idx);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            remain_reg <= '0;
            m_oe_reg   <= 1'b0;
            m_ld_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            src_reg    <= src_next;
            dst_reg    <= dst_next;
            remain_reg <= remain_next;
            m_oe_reg   <= m_oe_next;
            m_ld_reg   <= m_ld_next;
        end
    end

    assign burstBusy = (state_reg == RUN);
    assign burstDone = (state_reg == DONE);
`else
    logic unused_burst;
    assign unused_burst = burstStart ^ (^burstCount);

    always_comb begin
        oe_n_next = strobe_n(oe, oe_idx);
        ld_n_next = strobe_n(load, load_idx);
    end

    assign burstBusy = 1'b0;
    assign burstDone = 1'b0;
`endif
endmodule

// File: tb/tb_regsel_burst.sv
// Self-checking bench for regsel_burst (REG_COUNT=8): decode table, burst corner
// sequences and a randomized run against a queue-based reference model.
module tb_regsel_burst;
    localparam int N = 8;
    localparam int W = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         oe, load;
    logic [1:0]   oeSourceSel;
    logic         loadSourceSel;
    logic [W-1:0] useqRegSelOE, useqRegSelLoad, op0, op1, op2;
    logic         burstStart;
    logic [W:0]   burstCount;
    logic         burstBusy, burstDone;
    logic [N-1:0] regNotOEs, regNotLoads;

    int checks = 0;
    int failures = 0;

    regsel_burst #(.REG_COUNT(N), .SEL_WIDTH(W)) dut (
        .clock(clock), .reset(reset), .oe(oe), .load(load),
        .oeSourceSel(oeSourceSel), .loadSourceSel(loadSourceSel),
        .useqRegSelOE(useqRegSelOE), .useqRegSelLoad(useqRegSelLoad),
        .op0(op0), .op1(op1), .op2(op2),
        .burstStart(burstStart), .burstCount(burstCount),
        .burstBusy(burstBusy), .burstDone(burstDone),
        .regNotOEs(regNotOEs), .regNotLoads(regNotLoads)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       oe, load;
        logic [1:0] os;
        logic       ls;
        logic [2:0] uo, ul, o0, o1, o2;
        logic [7:0] eo, el;
    } vec_t;

    typedef struct packed {
        logic [7:0] eo;
        logic [7:0] el;
        logic       b;
        logic       d;
    } out_t;

    out_t model_q[$];

    task automatic check(string name, logic [7:0] eo, logic [7:0] el, logic eb, logic ed);
        checks++;
        if (regNotOEs !== eo || regNotLoads !== el || burstBusy !== eb || burstDone !== ed) begin
            failures++;
            $display("FAIL %s: got oe=%h ld=%h busy=%b done=%b, want oe=%h ld=%h busy=%b done=%b",
                     name, regNotOEs, regNotLoads, burstBusy, burstDone, eo, el, eb, ed);
        end else begin
            $display("ok   %s: oe=%h ld=%h busy=%b done=%b", name, regNotOEs, regNotLoads, burstBusy, burstDone);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        oe = 0; load = 0; oeSourceSel = 0; loadSourceSel = 0;
        useqRegSelOE = 0; useqRegSelLoad = 0; op0 = 0; op1 = 0; op2 = 0;
        burstStart = 0; burstCount = 0;
    endtask

    function automatic logic [7:0] dec(logic en, int idx);
        logic [7:0] one;
        one = 8'd1;
        if (en && idx < N) return ~(one << idx);
        return 8'hFF;
    endfunction

    function automatic int cur_oe_idx();
        case (oeSourceSel)
            2'd0:    return int'(useqRegSelOE);
            2'd1:    return int'(op0);
            2'd2:    return int'(op1);
            default: return int'(op2);
        endcase
    endfunction

    function automatic int cur_ld_idx();
        return loadSourceSel ? int'(op0) : int'(useqRegSelLoad);
    endfunction

    // Reference: a burst is expanded into its whole output sequence at acceptance.
    function automatic out_t model_step();
        out_t r;
        int s, d, c;
        if (model_q.size() > 0) return model_q.pop_front();
        s = cur_oe_idx();
        d = cur_ld_idx();
`ifdef REGSEL_BURST_EN
        if (burstStart) begin
            c = (int'(burstCount) > N) ? N : int'(burstCount);
            for (int i = 0; i < c; i++)
                model_q.push_back({dec(oe, (s + i) % N), dec(load, (d + i) % N), 1'b1, 1'b0});
            model_q.push_back({8'hFF, 8'hFF, 1'b0, 1'b1});
            return model_q.pop_front();
        end
`endif
        r = {dec(oe, s), dec(load, d), 1'b0, 1'b0};
        return r;
    endfunction

    vec_t vt[7];
    logic [7:0] copy_oe[4];
    logic [7:0] copy_ld[4];

    initial begin
        vt[0] = '{1, 1, 2'd0, 0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7, 8'hFB, 8'hFE};
        vt[1] = '{1, 1, 2'd1, 0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7, 8'hFD, 8'hFE};
        vt[2] = '{1, 1, 2'd2, 0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7, 8'hF7, 8'hFE};
        vt[3] = '{1, 1, 2'd3, 0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7, 8'h7F, 8'hFE};
        vt[4] = '{0, 0, 2'd3, 0, 3'd2, 3'd0, 3'd1, 3'd3, 3'd7, 8'hFF, 8'hFF};
        vt[5] = '{1, 1, 2'd0, 1, 3'd4, 3'd0, 3'd6, 3'd3, 3'd7, 8'hEF, 8'hBF};
        vt[6] = '{0, 1, 2'd1, 0, 3'd4, 3'd5, 3'd6, 3'd3, 3'd7, 8'hFF, 8'hDF};
        copy_oe = '{8'hFB, 8'hF7, 8'hEF, 8'hDF};
        copy_ld = '{8'hDF, 8'hBF, 8'h7F, 8'hFE};

        quiet();
        #1 reset = 1;
        #1 check("reset_async", 8'hFF, 8'hFF, 0, 0);
        tick();
        tick();
        reset = 0;
        check("reset_hold", 8'hFF, 8'hFF, 0, 0);

        foreach (vt[k]) begin
            oe = vt[k].oe; load = vt[k].load; oeSourceSel = vt[k].os; loadSourceSel = vt[k].ls;
            useqRegSelOE = vt[k].uo; useqRegSelLoad = vt[k].ul;
            op0 = vt[k].o0; op1 = vt[k].o1; op2 = vt[k].o2;
            tick();
            check($sformatf("decode_%0d", k), vt[k].eo, vt[k].el, 0, 0);
        end

`ifdef REGSEL_BURST_EN
        // Burst copy 2 -> 5, four steps with destination wrap.
        quiet();
        oe = 1; load = 1; useqRegSelOE = 2; op0 = 5; loadSourceSel = 1;
        burstCount = 4; burstStart = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            quiet();
            check($sformatf("copy_step%0d", i), copy_oe[i], copy_ld[i], 1, 0);
        end
        oe = 1; load = 1; oeSourceSel = 2; op1 = 3;
        tick();
        check("copy_done", 8'hFF, 8'hFF, 0, 1);
        tick();
        check("copy_resume", 8'hF7, 8'hFE, 0, 0);

        // Masked and clamped: 12 -> 8 steps, loads masked off.
        quiet();
        oe = 1; useqRegSelOE = 6; burstCount = 12; burstStart = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            quiet();
            check($sformatf("clamp_step%0d", i), dec(1'b1, (6 + i) % 8), 8'hFF, 1, 0);
        end
        tick();
        check("clamp_done", 8'hFF, 8'hFF, 0, 1);

        // Zero count.
        quiet();
        oe = 1; load = 1; useqRegSelOE = 3; burstCount = 0; burstStart = 1;
        tick();
        quiet();
        check("zero_done", 8'hFF, 8'hFF, 0, 1);
        oe = 1; op0 = 4; oeSourceSel = 1;
        tick();
        check("zero_resume", 8'hEF, 8'hFF, 0, 0);

        // Restart ignored while busy, then reset at step 2.
        quiet();
        oe = 1; load = 1; op0 = 3; loadSourceSel = 1; burstCount = 6; burstStart = 1;
        tick();
        check("busy_step0", 8'hFE, 8'hF7, 1, 0);
        oeSourceSel = 2; op1 = 5; burstCount = 1;
        tick();
        check("busy_step1", 8'hFD, 8'hEF, 1, 0);
        burstStart = 0;
        tick();
        check("busy_step2", 8'hFB, 8'hDF, 1, 0);
        #1 reset = 1;
        #1 check("abort", 8'hFF, 8'hFF, 0, 0);
        tick();
        reset = 0;
        quiet();
        oe = 1; load = 1; oeSourceSel = 3; op2 = 6; useqRegSelLoad = 1;
        tick();
        check("abort_resume", 8'hBF, 8'hFD, 0, 0);
`else
        quiet();
        oe = 1; load = 1; oeSourceSel = 1; op0 = 1; burstCount = 4; burstStart = 1;
        tick();
        check("noburst_0", 8'hFD, 8'hFE, 0, 0);
        oeSourceSel = 2; op1 = 6; load = 0;
        tick();
        check("noburst_1", 8'hBF, 8'hFF, 0, 0);
`endif

        // Randomized run against the reference model.
        quiet();
        tick();
        model_q.delete();
        for (int n = 0; n < 300; n++) begin
            out_t e;
            oe = 1'($urandom); load = 1'($urandom);
            oeSourceSel = 2'($urandom); loadSourceSel = 1'($urandom);
            useqRegSelOE = 3'($urandom); useqRegSelLoad = 3'($urandom);
            op0 = 3'($urandom); op1 = 3'($urandom); op2 = 3'($urandom);
            burstStart = ($urandom_range(0, 5) == 0);
            burstCount = 4'($urandom_range(0, 15));
            e = model_step();
            tick();
            check($sformatf("rand_%0d", n), e.eo, e.el, e.b, e.d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
